// File: rtl/uart_rx.sv
// 8N1 UART receiver. A 2-FF synchroniser feeds a mid-bit sampling FSM.
// Each good byte is delivered with a one-cycle o_valid strobe; a low stop bit raises a one-cycle o_frameError strobe.
module uart_rx #(
    parameter int CLK_FREQUENCY  = 100_000_000,
    parameter int UART_FREQUENCY = 9_200,
    parameter int DATA_SIZE      = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_rx,
    output logic [DATA_SIZE-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frameError,
    output logic                 o_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQUENCY / UART_FREQUENCY;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_SIZE + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_SIZE - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_baud
            $error("uart_rx: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_SIZE-1:0] shift;
    logic                 rx_meta;
    logic                 rxs;

    // NOTE: non-blocking (<=) for every flop so all registers update together on the edge.
    // Both stages reset to the idle-high line level, so reset never looks like a start bit.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rxs     <= rx_meta;
        end
    end

    // NOTE: reset is synchronous here, so it is tested inside the clocked block and not in the sensitivity list.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            shift        <= '0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_frameError <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            o_valid      <= 1'b0;
            o_frameError <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!rxs) begin
                        state  <= START;
                        o_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        idx <= '0;
                        if (!rxs) begin
                            state <= DATA;
                        end else begin
                            // Line went back high before mid-start: treat it as a glitch.
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shift <= {rxs, shift[DATA_SIZE-1:1]};
                        if (idx == IDX_LAST) begin
                            idx   <= '0;
                            state <= STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rxs) begin
                            // Return at mid-stop so a start edge right after the stop bit is caught.
                            o_data  <= shift;
                            o_valid <= 1'b1;
                            state   <= IDLE;
                            o_busy  <= 1'b0;
                        end else begin
                            o_frameError <= 1'b1;
                            state        <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rxs) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at a fast baud (50 clocks per bit) so every frame stays short.
// The expected values are hand-derived constants.
module tb_uart_rx;

    localparam int CLK_F = 100_000_000;
    localparam int BAUD  = 2_000_000;
    localparam int C     = 50;            // clocks per bit at these settings
    localparam int H     = 25;            // half bit
    localparam int LAT   = H + 9 * C + 3; // pin fall to o_valid, in clocks

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       fe;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx #(
        .CLK_FREQUENCY (CLK_F),
        .UART_FREQUENCY(BAUD),
        .DATA_SIZE     (8)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_rx        (rx),
        .o_data      (data),
        .o_valid     (valid),
        .o_frameError(fe),
        .o_busy      (busy)
    );

    int         n_tests     = 0;
    int         n_fail      = 0;
    int         valid_cnt   = 0;
    int         fe_cnt      = 0;
    int         overlap_cnt = 0;
    logic [7:0] rx_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            rx_q.push_back(data);
        end
        if (fe) fe_cnt++;
        if (valid && fe) overlap_cnt++;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame with a bit period of p100/100 clocks; the caller is aligned at posedge+1.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int p100);
        logic [9:0] bits;
        int prev;
        int nxt;
        bits = {stop_bit, b, 1'b0};
        prev = 0;
        for (int k = 0; k < 10; k++) begin
            rx  = bits[k];
            nxt = ((k + 1) * p100 + 50) / 100;
            cycles(nxt - prev);
            prev = nxt;
        end
    endtask

    function automatic logic [31:0] q_at(input int k);
        return (rx_q.size() > k) ? {24'd0, rx_q[k]} : 32'hDEAD;
    endfunction

    int lat;
    int vc0;
    int fc0;

    initial begin
        cycles(4);
        check("reset o_data", data, 0);
        check("reset o_valid", valid, 0);
        check("reset o_frameError", fe, 0);
        check("reset o_busy", busy, 0);
        rst = 1'b0;
        cycles(1);

        // 1: single byte, with latency from the pin edge
        rx_q.delete();
        lat = -1;
        fork
            send_frame(8'hA5, 1'b1, 5000);
            begin
                for (int n = 1; n <= 1000; n++) begin
                    cycles(1);
                    if (valid) begin
                        lat = n;
                        break;
                    end
                end
            end
        join
        cycles(20);
        check("t1 latency", lat, LAT);
        check("t1 valid count", valid_cnt, 1);
        check("t1 data", data, 8'hA5);
        check("t1 byte", q_at(0), 8'hA5);
        check("t1 no frame error", fe_cnt, 0);
        check("t1 busy low", busy, 0);

        // 2: short low glitch is rejected at mid-start
        vc0 = valid_cnt;
        rx = 1'b0;
        cycles(6);
        check("t2 busy during glitch", busy, 1);
        cycles(4);
        rx = 1'b1;
        cycles(40);
        check("t2 busy after glitch", busy, 0);
        check("t2 no valid", valid_cnt, vc0);
        check("t2 no frame error", fe_cnt, 0);

        // 3: low stop bit, line held low, then released
        send_frame(8'h3C, 1'b0, 5000);
        cycles(2 * C);
        check("t3 one frame error", fe_cnt, 1);
        check("t3 data kept", data, 8'hA5);
        check("t3 no valid", valid_cnt, vc0);
        check("t3 busy in break", busy, 1);
        rx = 1'b1;
        cycles(10);
        check("t3 busy after break", busy, 0);
        check("t3 still one frame error", fe_cnt, 1);
        check("t3 still no valid", valid_cnt, vc0);

        // 4: back-to-back frames with no idle gap
        rx_q.delete();
        send_frame(8'h00, 1'b1, 5000);
        send_frame(8'hFF, 1'b1, 5000);
        send_frame(8'h55, 1'b1, 5000);
        cycles(20);
        check("t4 count", rx_q.size(), 3);
        check("t4 byte0", q_at(0), 8'h00);
        check("t4 byte1", q_at(1), 8'hFF);
        check("t4 byte2", q_at(2), 8'h55);

        // 5: reset during data bit 4 aborts the frame silently
        vc0 = valid_cnt;
        fc0 = fe_cnt;
        fork
            send_frame(8'hF0, 1'b1, 5000);
            begin
                cycles(5 * C + H);
                rst = 1'b1;
                cycles(1);
                rst = 1'b0;
            end
        join
        cycles(20);
        check("t5 no valid on abort", valid_cnt, vc0);
        check("t5 no frame error on abort", fe_cnt, fc0);
        check("t5 data cleared", data, 0);
        check("t5 busy low", busy, 0);
        rx_q.delete();
        send_frame(8'h81, 1'b1, 5000);
        cycles(20);
        check("t5 count after", rx_q.size(), 1);
        check("t5 byte after", q_at(0), 8'h81);
        check("t5 data after", data, 8'h81);

        // 6: +3% and -3% baud mismatch
        rx_q.delete();
        send_frame(8'hC3, 1'b1, 4854);
        cycles(20);
        check("t6 fast count", rx_q.size(), 1);
        check("t6 fast byte", q_at(0), 8'hC3);
        rx_q.delete();
        send_frame(8'hC3, 1'b1, 5155);
        cycles(20);
        check("t6 slow count", rx_q.size(), 1);
        check("t6 slow byte", q_at(0), 8'hC3);

        check("valid and frame error never together", overlap_cnt, 0);
        check("total frame errors", fe_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
